// File: rtl/alu_rr_sched.sv
// Round-robin scheduler sharing one combinational 8-bit ALU between two requesters.
// Define ALU_SCHED_OPCODE_CHECK_EN to reject reserved opcode 5'b10000 with rsp_err.
module alu_rr_sched #(
  parameter int unsigned HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic [4:0]  req0_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  input  logic [4:0]  req1_op,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_carry,
  output logic        rsp_err,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [4:0]  alu_opcode,
  input  logic [15:0] alu_out,
  input  logic        alu_carry
);

  if (HOLD_CYCLES == 0 || HOLD_CYCLES > 15) begin : g_hold_range_check
    $error("HOLD_CYCLES must be in 1..15");
  end

  typedef enum logic [1:0] {StIdle, StIssue, StResp} state_e;

  state_e      state_q, state_d;
  logic        last_q, last_d;
  logic        owner_q, owner_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  alu_a_q, alu_a_d;
  logic [7:0]  alu_b_q, alu_b_d;
  logic [4:0]  alu_op_q, alu_op_d;
  logic [15:0] data_q, data_d;
  logic        carry_q, carry_d;
  logic        err_q, err_d;
  logic        rsp0_valid_q, rsp0_valid_d;
  logic        rsp1_valid_q, rsp1_valid_d;

  logic        grant0, grant1, accept, reserved;
  logic [7:0]  sel_a, sel_b;
  logic [4:0]  sel_op;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == StIdle && !rst) begin
      grant0 = req0_valid && (!req1_valid || last_q);
      grant1 = req1_valid && (!req0_valid || !last_q);
    end
  end

  assign accept = grant0 | grant1;
  assign sel_a  = grant1 ? req1_a  : req0_a;
  assign sel_b  = grant1 ? req1_b  : req0_b;
  assign sel_op = grant1 ? req1_op : req0_op;

`ifdef ALU_SCHED_OPCODE_CHECK_EN
  assign reserved = (sel_op == 5'b10000);
`else
  assign reserved = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    owner_d      = owner_q;
    cnt_d        = cnt_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    data_d       = data_q;
    carry_d      = carry_q;
    err_d        = err_q;
    rsp0_valid_d = rsp0_valid_q;
    rsp1_valid_d = rsp1_valid_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          owner_d = grant1;
          last_d  = grant1;
          if (reserved) begin
            // Rejected opcode never reaches the ALU; answer immediately with an error.
            data_d       = 16'h0000;
            carry_d      = 1'b0;
            err_d        = 1'b1;
            rsp0_valid_d = !grant1;
            rsp1_valid_d = grant1;
            state_d      = StResp;
          end else begin
            alu_a_d  = sel_a;
            alu_b_d  = sel_b;
            alu_op_d = sel_op;
            cnt_d    = 4'(HOLD_CYCLES);
            state_d  = StIssue;
          end
        end
      end
      StIssue: begin
        if (cnt_q == 4'd1) begin
          data_d       = alu_out;
          carry_d      = alu_carry;
          err_d        = 1'b0;
          rsp0_valid_d = !owner_q;
          rsp1_valid_d = owner_q;
          state_d      = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if ((rsp0_valid_q && rsp0_ready) || (rsp1_valid_q && rsp1_ready)) begin
          rsp0_valid_d = 1'b0;
          rsp1_valid_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_q       <= 1'b1;
      owner_q      <= 1'b0;
      cnt_q        <= '0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      data_q       <= '0;
      carry_q      <= 1'b0;
      err_q        <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp1_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      owner_q      <= owner_d;
      cnt_q        <= cnt_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      data_q       <= data_d;
      carry_q      <= carry_d;
      err_q        <= err_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp1_valid_q <= rsp1_valid_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp0_valid = rsp0_valid_q;
  assign rsp1_valid = rsp1_valid_q;
  assign rsp_data   = data_q;
  assign rsp_carry  = carry_q;
  assign rsp_err    = err_q;
  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_opcode = alu_op_q;

endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched: directed scenarios plus a randomized run against a transaction model.
// Expectations follow ALU_SCHED_OPCODE_CHECK_EN when it is defined.
module tb_alu_rr_sched;

`ifdef ALU_SCHED_OPCODE_CHECK_EN
  localparam bit CheckEn = 1'b1;
`else
  localparam bit CheckEn = 1'b0;
`endif
  localparam int Hold1 = 1;

  logic clk, rst;
  logic req0_valid, req0_ready, req1_valid, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0] req0_op, req1_op;
  logic rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [15:0] rsp_data, alu_out;
  logic rsp_carry, rsp_err, alu_carry;
  logic [7:0] alu_a, alu_b;
  logic [4:0] alu_opcode;

  logic h_req0_valid, h_req0_ready, h_req1_valid, h_req1_ready;
  logic [7:0] h_req0_a, h_req0_b, h_req1_a, h_req1_b;
  logic [4:0] h_req0_op, h_req1_op;
  logic h_rsp0_valid, h_rsp0_ready, h_rsp1_valid, h_rsp1_ready;
  logic [15:0] h_rsp_data, h_alu_out;
  logic h_rsp_carry, h_rsp_err, h_alu_carry;
  logic [7:0] h_alu_a, h_alu_b;
  logic [4:0] h_alu_opcode;

  // ALU stand-in: result is the concatenated operands, carry is opcode bit 0.
  assign alu_out     = {alu_a, alu_b};
  assign alu_carry   = alu_opcode[0];
  assign h_alu_out   = {h_alu_a, h_alu_b};
  assign h_alu_carry = h_alu_opcode[0];

  alu_rr_sched #(.HOLD_CYCLES(Hold1)) u_dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opcode(alu_opcode),
    .alu_out(alu_out), .alu_carry(alu_carry)
  );

  alu_rr_sched #(.HOLD_CYCLES(4)) u_dut_hold4 (
    .clk(clk), .rst(rst),
    .req0_valid(h_req0_valid), .req0_ready(h_req0_ready),
    .req0_a(h_req0_a), .req0_b(h_req0_b), .req0_op(h_req0_op),
    .req1_valid(h_req1_valid), .req1_ready(h_req1_ready),
    .req1_a(h_req1_a), .req1_b(h_req1_b), .req1_op(h_req1_op),
    .rsp0_valid(h_rsp0_valid), .rsp0_ready(h_rsp0_ready),
    .rsp1_valid(h_rsp1_valid), .rsp1_ready(h_rsp1_ready),
    .rsp_data(h_rsp_data), .rsp_carry(h_rsp_carry), .rsp_err(h_rsp_err),
    .alu_a(h_alu_a), .alu_b(h_alu_b), .alu_opcode(h_alu_opcode),
    .alu_out(h_alu_out), .alu_carry(h_alu_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors, checks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    req0_valid = 0; req0_a = 0; req0_b = 0; req0_op = 0;
    req1_valid = 0; req1_a = 0; req1_b = 0; req1_op = 0;
    rsp0_ready = 0; rsp1_ready = 0;
    h_req0_valid = 0; h_req0_a = 0; h_req0_b = 0; h_req0_op = 0;
    h_req1_valid = 0; h_req1_a = 0; h_req1_b = 0; h_req1_op = 0;
    h_rsp0_ready = 0; h_rsp1_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    rst = 0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

  int order[$];
  int k0, k1, n, g;
  logic [15:0] exp_rsp;
  bit pv[2], rr[2];
  logic [7:0] pa[2], pb[2];
  logic [4:0] pop[2];
  bit m_busy, m_last, m_carry, m_err, rv, resv;
  int m_due, m_own;
  logic [15:0] m_data;

  initial begin
    errors = 0; checks = 0;
    rst = 1;
    idle_inputs();
    @(negedge clk);
    do_reset();
    #1;
    chk("rst_req0_ready", req0_ready, 0);
    chk("rst_req1_ready", req1_ready, 0);
    chk("rst_rsp0_valid", rsp0_valid, 0);
    chk("rst_rsp1_valid", rsp1_valid, 0);
    chk("rst_alu", {alu_a, alu_b, alu_opcode}, 0);
    chk("rst_rsp", {rsp_data, rsp_carry, rsp_err}, 0);
    chk("rst_h_out", {h_alu_a, h_alu_b, h_alu_opcode, h_rsp_data, h_rsp_carry, h_rsp_err}, 0);

    // Single request
    req0_valid = 1; req0_a = 8'h67; req0_b = 8'h98; req0_op = 5'b00001; rsp0_ready = 1;
    #1;
    chk("single_accept", req0_ready, 1);
    chk("single_req1_ready", req1_ready, 0);
    @(negedge clk); req0_valid = 0; #1;
    chk("single_issue_valid", rsp0_valid, 0);
    chk("single_alu", {alu_a, alu_b, alu_opcode}, {8'h67, 8'h98, 5'b00001});
    @(negedge clk); #1;
    chk("single_rsp_valid", rsp0_valid, 1);
    chk("single_rsp_data", rsp_data, 16'h6798);
    chk("single_rsp_carry", rsp_carry, 1);
    chk("single_rsp_err", rsp_err, 0);
    chk("single_rsp1_valid", rsp1_valid, 0);
    @(negedge clk); #1;
    chk("single_done", {rsp0_valid, rsp1_valid}, 0);

    // Tie after reset: three back-to-back requests per side
    do_reset();
    rsp0_ready = 1; rsp1_ready = 1; k0 = 0; k1 = 0;
    for (int c = 0; c < 40; c++) begin
      req0_valid = (k0 < 3); req0_a = 8'(8'hA0 + k0); req0_b = 8'(8'h50 + k0); req0_op = 5'(k0);
      req1_valid = (k1 < 3); req1_a = 8'(8'hB0 + k1); req1_b = 8'(8'hC0 + k1); req1_op = 5'(k1 + 4);
      #1;
      if (req0_ready) begin
        order.push_back(0); exp_rsp = {req0_a, req0_b}; k0++;
      end else if (req1_ready) begin
        order.push_back(1); exp_rsp = {req1_a, req1_b}; k1++;
      end
      if (rsp0_valid || rsp1_valid) begin
        if (order.size() > 0) chk("tie_rsp_owner", rsp1_valid, order[$]);
        else chk("tie_rsp_before_grant", {rsp0_valid, rsp1_valid}, 0);
        chk("tie_rsp_data", rsp_data, exp_rsp);
      end
      @(negedge clk);
    end
    chk("tie_grant_count", order.size(), 6);
    for (int i = 0; i < order.size(); i++) chk("tie_grant_order", order[i], i % 2);

    // Backpressure on rsp1 while req0 waits
    idle_inputs();
    req1_valid = 1; req1_a = 8'h3C; req1_b = 8'hC5; req1_op = 5'b00110; rsp0_ready = 1;
    #1;
    chk("bp_accept", req1_ready, 1);
    @(negedge clk);
    req1_valid = 0;
    req0_valid = 1; req0_a = 8'h11; req0_b = 8'h22; req0_op = 5'b00011;
    n = 0;
    while (!rsp1_valid && n < 10) begin @(negedge clk); n++; end
    chk("bp_rsp_rise", rsp1_valid, 1);
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_valid_held", rsp1_valid, 1);
      chk("bp_data_held", rsp_data, 16'h3CC5);
      chk("bp_carry_held", rsp_carry, 0);
      chk("bp_req0_blocked", req0_ready, 0);
      @(negedge clk);
    end
    rsp1_ready = 1; #1;
    chk("bp_req0_blocked_consume", req0_ready, 0);
    @(negedge clk); rsp1_ready = 0; #1;
    chk("bp_consumed", rsp1_valid, 0);
    chk("bp_req0_accept", req0_ready, 1);
    @(negedge clk); req0_valid = 0;
    @(negedge clk); #1;
    chk("bp_req0_rsp", rsp0_valid, 1);
    chk("bp_req0_data", {rsp_data, rsp_carry}, {16'h1122, 1'b1});
    @(negedge clk);

    // Hold window with HOLD_CYCLES = 4
    h_req0_valid = 1; h_req0_a = 8'h5A; h_req0_b = 8'hC3; h_req0_op = 5'b11111; h_rsp0_ready = 1;
    #1;
    chk("hold_accept", h_req0_ready, 1);
    @(negedge clk); h_req0_valid = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("hold_alu", {h_alu_a, h_alu_b, h_alu_opcode}, {8'h5A, 8'hC3, 5'b11111});
      chk("hold_no_rsp", h_rsp0_valid, 0);
      @(negedge clk);
    end
    #1;
    chk("hold_rsp_valid", h_rsp0_valid, 1);
    chk("hold_rsp_data", {h_rsp_data, h_rsp_carry, h_rsp_err}, {16'h5AC3, 1'b1, 1'b0});
    chk("hold_other_side", {h_req1_ready, h_rsp1_valid}, 0);
    @(negedge clk);

    // Reset mid-ISSUE (last owner was req0, so only reset can hand the tie back to req0)
    req0_valid = 1; req0_a = 8'hAA; req0_b = 8'h55; req0_op = 5'b00001; rsp0_ready = 1;
    #1;
    chk("rstmid_accept", req0_ready, 1);
    @(negedge clk); req0_valid = 0; rst = 1;
    @(negedge clk); rst = 0; #1;
    chk("rstmid_alu_zero", {alu_a, alu_b, alu_opcode}, 0);
    chk("rstmid_rsp_zero", {rsp_data, rsp_carry, rsp_err}, 0);
    for (int c = 0; c < 3; c++) begin
      chk("rstmid_no_rsp", {rsp0_valid, rsp1_valid}, 0);
      @(negedge clk); #1;
    end
    req0_valid = 1; req0_a = 8'h12; req0_b = 8'h34; req0_op = 5'b00011;
    req1_valid = 1; req1_a = 8'h77; req1_b = 8'h88; req1_op = 5'b00010;
    #1;
    chk("rstmid_tie_req0", req0_ready, 1);
    chk("rstmid_tie_req1", req1_ready, 0);
    @(negedge clk); req0_valid = 0; req1_valid = 0;
    @(negedge clk);
    @(negedge clk); rsp0_ready = 0;

    // Reserved opcode
    req0_valid = 1; req0_a = 8'h67; req0_b = 8'h98; req0_op = 5'b10000;
    #1;
    chk("resv_accept", req0_ready, 1);
    @(negedge clk); req0_valid = 0; #1;
`ifdef ALU_SCHED_OPCODE_CHECK_EN
    chk("resv_rsp_valid", rsp0_valid, 1);
    chk("resv_rsp", {rsp_data, rsp_carry, rsp_err}, {16'h0000, 1'b0, 1'b1});
    chk("resv_alu_kept", {alu_a, alu_b, alu_opcode}, {8'h12, 8'h34, 5'b00011});
`else
    chk("resv_issue", rsp0_valid, 0);
    chk("resv_alu_fwd", alu_opcode, 5'b10000);
    @(negedge clk); #1;
    chk("resv_rsp_valid", rsp0_valid, 1);
    chk("resv_rsp", {rsp_data, rsp_carry, rsp_err}, {16'h6798, 1'b0, 1'b0});
`endif
    rsp0_ready = 1;
    @(negedge clk); rsp0_ready = 0; #1;
    chk("resv_done", rsp0_valid, 0);

    // Randomized traffic against a transaction-level model
    do_reset();
    pv[0] = 0; pv[1] = 0; m_busy = 0; m_last = 1; m_due = 0; m_own = 0;
    m_data = 0; m_carry = 0; m_err = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        if (pv[i] && $urandom_range(0, 7) == 0) pv[i] = 0;
        else if (!pv[i] && $urandom_range(0, 1) == 1) begin
          pv[i] = 1; pa[i] = 8'($urandom); pb[i] = 8'($urandom); pop[i] = 5'($urandom);
        end
        rr[i] = 1'($urandom_range(0, 1));
      end
      req0_valid = pv[0]; req0_a = pa[0]; req0_b = pb[0]; req0_op = pop[0];
      req1_valid = pv[1]; req1_a = pa[1]; req1_b = pb[1]; req1_op = pop[1];
      rsp0_ready = rr[0]; rsp1_ready = rr[1];
      #1;
      g = -1;
      if (!m_busy) begin
        if (pv[0] && pv[1]) g = m_last ? 0 : 1;
        else if (pv[0]) g = 0;
        else if (pv[1]) g = 1;
      end
      chk("rnd_req0_ready", req0_ready, g == 0);
      chk("rnd_req1_ready", req1_ready, g == 1);
      rv = m_busy && (cyc >= m_due);
      chk("rnd_rsp0_valid", rsp0_valid, rv && m_own == 0);
      chk("rnd_rsp1_valid", rsp1_valid, rv && m_own == 1);
      if (rv) begin
        chk("rnd_rsp_data", rsp_data, m_data);
        chk("rnd_rsp_flags", {rsp_carry, rsp_err}, {m_carry, m_err});
        if (rr[m_own]) m_busy = 0;
      end
      if (g >= 0) begin
        resv    = CheckEn && (pop[g] == 5'b10000);
        m_busy  = 1;
        m_own   = g;
        m_last  = (g == 1);
        m_due   = cyc + 1 + (resv ? 0 : Hold1);
        m_data  = resv ? 16'h0000 : {pa[g], pb[g]};
        m_carry = resv ? 1'b0 : pop[g][0];
        m_err   = resv;
        pv[g]   = 0;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_rr_sched.md
# alu_rr_sched

Round-robin scheduler that shares one combinational 8-bit, 32-function ALU between two requesters. Each requester submits an operation (A, B, 5-bit opcode) over a valid/ready handshake. The scheduler arbitrates and drives the ALU inputs for a fixed settle window, then captures the 16-bit result and carry and returns them to the winning requester over a valid/ready response channel. It sits between the instruction/test front-ends and the shared ALU datapath.

## Interface
- HOLD_CYCLES, 1: cycles the ALU inputs are held stable before the result is sampled; legal range is 1..15, and 0 is illegal.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- req0_valid, req1_valid  input  1  request present.
- req0_ready, req1_ready  output  1  request accepted this cycle when ready and valid are both high.
- req0_a, req1_a  input  8  operand A.
- req0_b, req1_b  input  8  operand B.
- req0_op, req1_op  input  5  ALU opcode.
- rsp0_valid, rsp1_valid  output  1  response present.
- rsp0_ready, rsp1_ready  input  1  response consumed.
- rsp_data  output  16  captured ALU_Out; shared by both response channels.
- rsp_carry  output  1  captured CarryOut.
- rsp_err  output  1  response carries a rejected opcode. Tied to 0 unless the macro described under Configuration is defined.
- alu_a, alu_b  output  8  to the ALU A and B inputs.
- alu_opcode  output  5  to the ALU Opcode input.
- alu_out  input  16  from ALU_Out.
- alu_carry  input  1  from CarryOut.

## Operation
- **FSM states:** IDLE, ISSUE, RESP.
- **IDLE arbitration:**
  - The grant goes to the single valid requester.
  - If both requesters are valid, the grant goes to the one not granted last. The `last` pointer resets to 1, so req0 wins the first tie.
  - `reqN_ready` equals the grant and is combinational from the valids and `last`. It is 0 outside IDLE.
- **On accept (IDLE):**
  - Latch a, b and op into alu_a, alu_b and alu_opcode.
  - Record the owner and set `last` to the owner.
  - Load the hold counter with HOLD_CYCLES, then go to ISSUE.
- **ISSUE:**
  - alu_* outputs are held constant.
  - The counter decrements each cycle.
  - In the cycle the counter reaches 1: capture alu_out into rsp_data and alu_carry into rsp_carry, then go to RESP.
- **RESP:**
  - `rspN_valid` is high for the owner only.
  - rsp_data, rsp_carry and rsp_err are stable until the response is consumed.
  - When `rspN_ready` and `rspN_valid` are both high, go to IDLE.
  - The other requester's ready stays 0 throughout, so its request waits.
- alu_* outputs retain their last values outside ISSUE; no glitch-to-zero.
- A requester may drop valid before it is accepted; no request is lost or duplicated.
- Responses complete in grant order, which is trivially satisfied because only one operation is ever in flight.

## Timing
- **Reset values:**
  - State IDLE, `last` = 1.
  - All ready and valid outputs 0.
  - alu_a, alu_b, alu_opcode, rsp_data, rsp_carry and rsp_err all 0.
- **Latency:** accept edge (cycle 0) to rspN_valid high is HOLD_CYCLES + 1 cycles. With the default, valid rises 2 cycles after accept.
- **Throughput:** an IDLE cycle is required between operations. The minimum spacing between accepts is HOLD_CYCLES + 2 cycles when the response is consumed immediately.
- **Response held:** if rspN_ready stays 0, the FSM stays in RESP indefinitely with data stable.
- **Reset in any state:** the in-flight operation is discarded, no response is issued, and all outputs take their reset values on the next edge.
- **Simultaneous events:** requests that arrive during ISSUE or RESP are not accepted until the next IDLE cycle, where they are arbitrated normally.

## Configuration
- **Macro:** ALU_SCHED_OPCODE_CHECK_EN.
- **Defined:**
  - Opcode 5'b10000 is reserved.
  - On accept of a reserved opcode: alu_* outputs are not updated and ISSUE is skipped. The FSM goes directly to RESP on the next cycle with rsp_data = 16'h0000, rsp_carry = 0 and rsp_err = 1.
  - rsp_err = 0 for all other opcodes.
  - Reserved-opcode latency is 1 cycle.
- **Undefined:**
  - All 32 opcodes are forwarded unchanged.
  - rsp_err is constant 0.

## Test plan
The bench models the ALU as alu_out = {alu_a, alu_b} and alu_carry = alu_opcode[0]. HOLD_CYCLES = 1 unless stated.
- **Single request:** req0 with a=8'h67, b=8'h98, op=5'b00001, rsp0_ready held 1. Required: req0_ready high in the accept cycle, rsp0_valid exactly 2 cycles later, rsp_data=16'h6798, rsp_carry=1, rsp1_valid never asserted.
- **Tie after reset:** req0 and req1 valid in the same cycle after reset, 3 back-to-back requests each. Required: grant order 0,1,0,1,0,1, and each rsp_data matches its requester's operands.
- **Backpressure:** rsp1_ready held 0 for 5 cycles after rsp1_valid rises. Required: rsp1_valid, rsp_data and rsp_carry stable for all 5 cycles; req0_ready stays 0; req0 is accepted in the IDLE cycle after consumption.
- **Hold window:** HOLD_CYCLES=4, op=5'b11111. Required: alu_opcode=5'b11111 and alu_a/alu_b constant for 4 cycles, rsp0_valid 5 cycles after accept.
- **Reset mid-ISSUE:** assert rst in the ISSUE cycle. Required: no rsp valid afterwards, all outputs zero, and the next tie is granted to req0.
- **Reserved opcode:** with ALU_SCHED_OPCODE_CHECK_EN, op=5'b10000. Required: rsp_err=1 and rsp_data=0 one cycle after accept, alu_opcode unchanged. Without the macro: a normal response with rsp_data=16'h6798, rsp_carry=0 and rsp_err=0.
